// File: rtl/cfg_seq_pkg.sv
// rtl/cfg_seq_pkg.sv - shared states, terminator word and timing helper for the self-write sequencer
package cfg_seq_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      WAIT    = 3'd2,
      SETUP   = 3'd3,
      STROBE  = 3'd4,
      HOLD    = 3'd5,
      RSTHOLD = 3'd6,
      DONE    = 3'd7
   } seq_state_t;

   // Word that ends a load early when the terminator option is compiled in
   localparam logic [31:0] CFG_END_WORD = 32'hFAB0_FAB1;

   // Width of the shared phase counter; wide enough for any realistic reset hold
   localparam int DLY_W = 16;

   // Cycles from one strobe to the next: fetch + read latency + setup + strobe + hold
   function automatic int strobe_period(input int rd_latency,
                                        input int setup_cycles,
                                        input int hold_cycles);
      return 2 + rd_latency + setup_cycles + hold_cycles;
   endfunction

endpackage

// File: rtl/cfg_seq_delay_cnt.sv
// rtl/cfg_seq_delay_cnt.sv - loadable down-counter with zero flag timing each multi-cycle phase
module cfg_seq_delay_cnt
   import cfg_seq_pkg::*;
#(
   parameter int W = DLY_W
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_value,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   // Load on phase entry, then count down and park at zero
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_value;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/cfg_selfwrite_seq.sv
// rtl/cfg_selfwrite_seq.sv - self-write configuration sequencer; CFG_SEQ_EARLY_STOP_EN adds terminator-word stop
module cfg_selfwrite_seq
   import cfg_seq_pkg::*;
#(
   parameter int ADDR_W       = 12,
   parameter int NUM_WORDS    = 4096,
   parameter int RD_LATENCY   = 1,
   parameter int SETUP_CYCLES = 2,
   parameter int HOLD_CYCLES  = 2,
   parameter int RST_CYCLES   = 5
) (
   input  logic              CLK,
   input  logic              resetn,
   input  logic              start,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_data,
   output logic [31:0]       SelfWriteData,
   output logic              SelfWriteStrobe,
   output logic              fabric_rst,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   word_count
);

   // Counter reload values: the zero flag marks the last cycle of a phase
   localparam logic [DLY_W-1:0] LD_WAIT  = DLY_W'(RD_LATENCY - 1);
   localparam logic [DLY_W-1:0] LD_SETUP = DLY_W'(SETUP_CYCLES - 1);
   localparam logic [DLY_W-1:0] LD_HOLD  = DLY_W'(HOLD_CYCLES - 1);
   localparam logic [DLY_W-1:0] LD_RST   = DLY_W'(RST_CYCLES - 1);
   localparam logic [ADDR_W:0]  LAST_COUNT = (ADDR_W+1)'(NUM_WORDS);
   localparam int               PERIOD = strobe_period(RD_LATENCY, SETUP_CYCLES, HOLD_CYCLES);

   seq_state_t        r_state;
   seq_state_t        w_next;
   logic              w_dly_load;
   logic [DLY_W-1:0]  w_dly_value;
   logic              w_dly_zero;
   logic              w_clear;
   logic              w_capture;
   logic              w_addr_inc;
   logic              w_count_inc;
   logic              w_end_word;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_swd;
   logic [ADDR_W:0]   r_word_count;
   logic [DLY_W-1:0]  r_chk_gap;

`ifdef CFG_SEQ_EARLY_STOP_EN
   assign w_end_word = (mem_data == CFG_END_WORD);
`else
   assign w_end_word = 1'b0;
`endif

   cfg_seq_delay_cnt #(.W(DLY_W)) u_dly (
      .i_clk   (CLK),
      .i_rst_n (resetn),
      .i_load  (w_dly_load),
      .i_value (w_dly_value),
      .o_zero  (w_dly_zero)
   );

   // State register; an asserted reset aborts any load straight back to IDLE
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode plus the strobes that steer the datapath and phase counter
   always_comb begin
      w_next      = r_state;
      w_dly_load  = 1'b0;
      w_dly_value = '0;
      w_clear     = 1'b0;
      w_capture   = 1'b0;
      w_addr_inc  = 1'b0;
      w_count_inc = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_next  = FETCH;
               w_clear = 1'b1;
            end
         end
         FETCH: begin
            w_next      = WAIT;
            w_dly_load  = 1'b1;
            w_dly_value = LD_WAIT;
         end
         WAIT: begin
            if (w_dly_zero) begin
               w_dly_load = 1'b1;
               if (w_end_word) begin
                  w_next      = RSTHOLD;
                  w_dly_value = LD_RST;
               end else begin
                  w_next      = SETUP;
                  w_capture   = 1'b1;
                  w_dly_value = LD_SETUP;
               end
            end
         end
         SETUP: begin
            if (w_dly_zero) begin
               w_next = STROBE;
            end
         end
         STROBE: begin
            w_next      = HOLD;
            w_count_inc = 1'b1;
            w_dly_load  = 1'b1;
            w_dly_value = LD_HOLD;
         end
         HOLD: begin
            if (w_dly_zero) begin
               if (r_word_count == LAST_COUNT) begin
                  w_next      = RSTHOLD;
                  w_dly_load  = 1'b1;
                  w_dly_value = LD_RST;
               end else begin
                  w_next     = FETCH;
                  w_addr_inc = 1'b1;
               end
            end
         end
         RSTHOLD: begin
            if (w_dly_zero) begin
               w_next = DONE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // Datapath: word address, captured configuration word and strobe count
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         r_mem_addr   <= '0;
         r_swd        <= '0;
         r_word_count <= '0;
      end else begin
         if (w_clear) begin
            r_mem_addr   <= '0;
            r_word_count <= '0;
         end else begin
            if (w_addr_inc) begin
               r_mem_addr <= r_mem_addr + ADDR_W'(1);
            end
            if (w_count_inc) begin
               r_word_count <= r_word_count + (ADDR_W+1)'(1);
            end
         end
         if (w_capture) begin
            r_swd <= mem_data;
         end
      end
   end

   assign mem_rd          = (r_state == FETCH);
   assign mem_addr        = r_mem_addr;
   assign SelfWriteData   = r_swd;
   assign SelfWriteStrobe = (r_state == STROBE);
   assign fabric_rst      = (r_state == RSTHOLD);
   assign busy            = (r_state != IDLE) && (r_state != DONE);
   assign done            = (r_state == DONE);
   assign word_count      = r_word_count;

   // Cycles since the previous strobe of the current load; zero means no strobe yet
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         r_chk_gap <= '0;
      end else if (!busy) begin
         r_chk_gap <= '0;
      end else if (SelfWriteStrobe) begin
         r_chk_gap <= DLY_W'(1);
      end else if (r_chk_gap != '0) begin
         r_chk_gap <= r_chk_gap + DLY_W'(1);
      end
   end

   // Strobes within a load are exactly one period apart and never exceed the word budget
   always_ff @(posedge CLK) begin
      if (resetn) begin
         if (SelfWriteStrobe && (r_chk_gap != '0)) begin
            assert (r_chk_gap == DLY_W'(PERIOD));
         end
         assert (r_word_count <= LAST_COUNT);
      end
   end

endmodule

// File: tb/tb_cfg_selfwrite_seq.sv
// tb/tb_cfg_selfwrite_seq.sv - self-checking bench for cfg_selfwrite_seq
`timescale 1ns/1ps
module tb_cfg_selfwrite_seq;

   localparam int AW = 12;
   localparam int OW = 1 + AW + 32 + 1 + 1 + 1 + 1 + AW + 1;
   localparam logic [31:0] END_WORD = 32'hFAB0_FAB1;

   typedef struct {
      logic          start;
      logic [OW-1:0] exp;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   logic CLK = 1'b0;
   logic resetn = 1'b0;
   logic start_x = 1'b0;
   int   sel = 0;

   always #5 CLK = ~CLK;

   logic [31:0] mem4 [4];
   logic [31:0] mem_b [4096];

   logic          rd_a, rd_b, rd_c;
   logic [AW-1:0] addr_a, addr_b, addr_c;
   logic [31:0]   din_a, din_b, din_c;
   logic [31:0]   swd_a, swd_b, swd_c;
   logic          stb_a, stb_b, stb_c;
   logic          frst_a, frst_b, frst_c;
   logic          busy_a, busy_b, busy_c;
   logic          done_a, done_b, done_c;
   logic [AW:0]   wc_a, wc_b, wc_c;
   logic [31:0]   p1_c, p2_c;

   // Synchronous memories: data valid exactly RD_LATENCY edges after a read, garbage otherwise
   always @(posedge CLK) begin
      din_a <= rd_a ? mem4[addr_a[1:0]] : 32'hBAD0_0000;
      din_b <= rd_b ? mem_b[addr_b] : 32'hBAD0_0001;
      p1_c  <= rd_c ? mem4[addr_c[1:0]] : 32'hBAD0_0002;
      p2_c  <= p1_c;
      din_c <= p2_c;
   end

   cfg_selfwrite_seq #(.ADDR_W(AW), .NUM_WORDS(4)) dut_a (
      .CLK(CLK), .resetn(resetn), .start(start_x && (sel == 0)),
      .mem_rd(rd_a), .mem_addr(addr_a), .mem_data(din_a),
      .SelfWriteData(swd_a), .SelfWriteStrobe(stb_a), .fabric_rst(frst_a),
      .busy(busy_a), .done(done_a), .word_count(wc_a));

   cfg_selfwrite_seq #(.ADDR_W(AW), .NUM_WORDS(4096)) dut_b (
      .CLK(CLK), .resetn(resetn), .start(start_x && (sel == 1)),
      .mem_rd(rd_b), .mem_addr(addr_b), .mem_data(din_b),
      .SelfWriteData(swd_b), .SelfWriteStrobe(stb_b), .fabric_rst(frst_b),
      .busy(busy_b), .done(done_b), .word_count(wc_b));

   cfg_selfwrite_seq #(.ADDR_W(AW), .NUM_WORDS(4), .RD_LATENCY(3),
                       .SETUP_CYCLES(1), .HOLD_CYCLES(1)) dut_c (
      .CLK(CLK), .resetn(resetn), .start(start_x && (sel == 2)),
      .mem_rd(rd_c), .mem_addr(addr_c), .mem_data(din_c),
      .SelfWriteData(swd_c), .SelfWriteStrobe(stb_c), .fabric_rst(frst_c),
      .busy(busy_c), .done(done_c), .word_count(wc_c));

   wire [OW-1:0] out_a = {rd_a, addr_a, swd_a, stb_a, frst_a, busy_a, done_a, wc_a};
   wire [OW-1:0] out_b = {rd_b, addr_b, swd_b, stb_b, frst_b, busy_b, done_b, wc_b};
   wire [OW-1:0] out_c = {rd_c, addr_c, swd_c, stb_c, frst_c, busy_c, done_c, wc_c};
   wire [OW-1:0] out_s = (sel == 0) ? out_a : ((sel == 1) ? out_b : out_c);

   function automatic logic [OW-1:0] pack(input logic rd, input logic [AW-1:0] a,
                                          input logic [31:0] d, input logic stb,
                                          input logic frst, input logic bsy,
                                          input logic dn, input logic [AW:0] wc);
      return {rd, a, d, stb, frst, bsy, dn, wc};
   endfunction

   task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Expected per-cycle outputs of one load, derived from the phase lengths of each word
   task automatic build_table(input int n, input int l, input int s, input int h,
                              input int r, input int stop_k, input logic [31:0] prev);
      int p, nstb, rs, tlen, lastw;
      vec_t v;
      p     = 2 + l + s + h;
      nstb  = (stop_k >= 0) ? stop_k : n;
      rs    = nstb * p + ((stop_k >= 0) ? 1 + l : 0);
      tlen  = rs + r + 3;
      lastw = nstb - 1;
      tbl.delete();
      for (int c = 0; c < tlen; c++) begin
         int w, o, wm;
         logic [31:0] d;
         logic [AW:0] wc;
         v.start = (c == 0) ? 1'b1 : ((c <= rs + r) ? 1'($urandom_range(1)) : 1'b0);
         if (c < rs) begin
            w  = c / p;
            o  = c % p;
            wm = w - 1;
            if (o >= l + 1)  d = mem4[w[1:0]];
            else if (w > 0)  d = mem4[wm[1:0]];
            else             d = prev;
            wc = (AW+1)'(w + ((o > l + s + 1) ? 1 : 0));
            v.exp = pack(o == 0, AW'(w), d, o == l + s + 1, 1'b0, 1'b1, 1'b0, wc);
         end else begin
            d = (nstb > 0) ? mem4[lastw[1:0]] : prev;
            v.exp = pack(1'b0, AW'((stop_k >= 0) ? stop_k : n - 1), d, 1'b0,
                         c < rs + r, c < rs + r, c >= rs + r, (AW+1)'(nstb));
         end
         tbl.push_back(v);
      end
   endtask

   // Applies the table one clock per row; called and returns at a falling edge
   task automatic run_table(input string name);
      for (int i = 0; i < tbl.size(); i++) begin
         start_x = tbl[i].start;
         @(posedge CLK);
         @(negedge CLK);
         checks++;
         if (out_s !== tbl[i].exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, i, out_s, tbl[i].exp);
         end
      end
      start_x = 1'b0;
   endtask

   task automatic random_load();
      int cyc, nstb, last_chg, last_stb;
      logic [31:0] prev_d;
      sel = 1;
      start_x = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      start_x = 1'b0;
      cyc = 0; nstb = 0; last_chg = -100; last_stb = -100;
      prev_d = 32'h0;
      while (!done_b && cyc < 40000) begin
         if (swd_b !== prev_d) begin
            checks++;
            if (cyc - last_stb <= 2) begin
               errors++;
               $display("FAIL hold_window: data changed %0d cycles after strobe, required > 2", cyc - last_stb);
            end
            last_chg = cyc;
            prev_d = swd_b;
         end
         if (stb_b) begin
            checks++;
            if (nstb >= 4096 || swd_b !== mem_b[nstb[11:0]]) begin
               errors++;
               $display("FAIL strobe_data %0d: got %h expected %h", nstb, swd_b, mem_b[nstb[11:0]]);
            end
            checks++;
            if (cyc - last_chg < 2) begin
               errors++;
               $display("FAIL setup_window %0d: stable %0d cycles, required >= 2", nstb, cyc - last_chg);
            end
            if (nstb > 0) begin
               checks++;
               if (cyc - last_stb != 7) begin
                  errors++;
                  $display("FAIL strobe_period %0d: got %0d expected 7", nstb, cyc - last_stb);
               end
            end
            last_stb = cyc;
            nstb++;
         end
         @(negedge CLK);
         cyc++;
      end
      checks++;
      if (!done_b) begin
         errors++;
         $display("FAIL big_load_done: timed out after %0d cycles", cyc);
      end
      checks++;
      if (nstb != 4096) begin
         errors++;
         $display("FAIL big_load_strobes: got %0d expected 4096", nstb);
      end
      checks++;
      if (wc_b !== 13'd4096) begin
         errors++;
         $display("FAIL big_load_count: got %0d expected 4096", wc_b);
      end
   endtask

   initial begin
      mem4[0] = 32'h0000_0001;
      mem4[1] = 32'hDEAD_BEEF;
      mem4[2] = 32'h1234_5678;
      mem4[3] = 32'hFFFF_FFFF;
      for (int i = 0; i < 4096; i++) begin
         mem_b[i] = $urandom;
         if (mem_b[i] == END_WORD) mem_b[i] = mem_b[i] ^ 32'h1;
      end

      checks++;
      if (cfg_seq_pkg::strobe_period(1, 2, 2) != 7) begin
         errors++;
         $display("FAIL period_fn_default: got %0d expected 7", cfg_seq_pkg::strobe_period(1, 2, 2));
      end
      checks++;
      if (cfg_seq_pkg::strobe_period(3, 1, 1) != 7) begin
         errors++;
         $display("FAIL period_fn_lat3: got %0d expected 7", cfg_seq_pkg::strobe_period(3, 1, 1));
      end

      // Reset state of all instances, then still idle after release with no start
      repeat (2) @(negedge CLK);
      check("reset_a", out_a, '0);
      check("reset_b", out_b, '0);
      check("reset_c", out_c, '0);
      resetn = 1'b1;
      @(negedge CLK);
      check("idle_a", out_a, '0);

      // Basic 4-word load with starts sprinkled while busy, then a restart from DONE
      sel = 0;
      build_table(4, 1, 2, 2, 5, -1, 32'h0);
      run_table("load4");
      build_table(4, 1, 2, 2, 5, -1, 32'hFFFF_FFFF);
      run_table("restart_from_done");

      // Reset during the second word's SETUP, then a clean reload from address 0
      start_x = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      start_x = 1'b0;
      repeat (9) @(negedge CLK);
      check("pre_abort", out_a, pack(1'b0, 12'd1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0, 13'd1));
      #2 resetn = 1'b0;
      #1 check("async_abort", out_a, '0);
      @(negedge CLK);
      @(negedge CLK);
      resetn = 1'b1;
      @(negedge CLK);
      check("idle_after_abort", out_a, '0);
      build_table(4, 1, 2, 2, 5, -1, 32'h0);
      run_table("reload_after_abort");

      // Long read latency with minimal setup/hold
      sel = 2;
      build_table(4, 3, 1, 1, 5, -1, 32'h0);
      run_table("lat3");

      // Full-depth random load with setup/hold window checking
      random_load();

`ifdef CFG_SEQ_EARLY_STOP_EN
      sel = 0;
      mem4[0] = 32'hA5A5_0001;
      mem4[1] = 32'h5A5A_0002;
      mem4[2] = END_WORD;
      mem4[3] = 32'hC0C0_0003;
      build_table(4, 1, 2, 2, 5, 2, 32'h0);
      run_table("early_stop");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
